// File: rtl/log_mem_pkg.sv
// log_mem_pkg: shared state encodings and default widths for the capture log.
//   LOG_NB_DATA - default sample width (matches the gen_fir output)
//   LOG_NB_ADDR - default log address width (DEPTH = 2**LOG_NB_ADDR)
//   state_t     - capture FSM states
package log_mem_pkg;
    localparam int LOG_NB_DATA = 8;
    localparam int LOG_NB_ADDR = 10;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/ram_sdp.sv
// ram_sdp: simple dual-port RAM, one write port and one registered read port.
//   clk          - clock
//   rst_n        - async active-low reset, clears only the read data register
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata updates one cycle later, holds otherwise
//   rdata        - read data
module ram_sdp #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic               re,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);
    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
endmodule

// File: rtl/log_mem_capture.sv
// log_mem_capture: captures strobed filter samples into a log RAM and reads them back.
//   i_clock, i_reset (async, active-low)
//   i_enable/i_data      - sample strobe and sample
//   i_run                - start or restart a capture
//   i_rd_req/i_rd_addr   - readback request, data on o_rd_data one cycle later
//   o_rd_valid           - readback data valid pulse
//   o_busy/o_full/o_count - capture status
module log_mem_capture
    import log_mem_pkg::*;
#(
    parameter int NB_DATA = LOG_NB_DATA,
    parameter int NB_ADDR = LOG_NB_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_run,
    input  logic               i_rd_req,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic               o_busy,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_count
);
    localparam logic [NB_ADDR:0] LAST = {1'b0, {NB_ADDR{1'b1}}};

    state_t             state;
    logic [NB_ADDR-1:0] wr_ptr;
    logic               wr_en;
    logic               rd_en;

    // i_run has priority over both the sample write and a readback request
    assign wr_en = (state == ST_CAPTURE) && i_enable && !i_run;
    assign rd_en = (state != ST_CAPTURE) && i_rd_req && !i_run;

    always_ff @(posedge i_clock or negedge i_reset)
        if (!i_reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            o_count    <= '0;
            o_busy     <= 1'b0;
            o_full     <= 1'b0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= rd_en;
            if (i_run) begin
                state   <= ST_CAPTURE;
                wr_ptr  <= '0;
                o_count <= '0;
                o_busy  <= 1'b1;
                o_full  <= 1'b0;
            end else if (wr_en) begin
                wr_ptr  <= wr_ptr + NB_ADDR'(1);
                o_count <= o_count + (NB_ADDR+1)'(1);
                // last slot written: stop without wrapping
                if (o_count == LAST) begin
                    state  <= ST_DONE;
                    o_busy <= 1'b0;
                    o_full <= 1'b1;
                end
            end
        end

    ram_sdp #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) u_ram (
        .clk   (i_clock),
        .rst_n (i_reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (i_data),
        .re    (rd_en),
        .raddr (i_rd_addr),
        .rdata (o_rd_data)
    );
endmodule
